hazard_scoreboard: RTL and testbench
====================================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter RAW, default 4, register-address width; NREG = 2**RAW.
REQ-002 SHALL have parameter NSRC, default 3, source read ports per instruction (Rn, Rm, Rs).
REQ-003 SHALL have parameter MUL_LAT, default 3, multiply execute latency in cycles (legal 2..15).
REQ-004 SHALL have parameter CNT_W, default 16, performance counter width.
REQ-005 clk  in  1  sole clock; all state updates on the rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 ra_d, ra_e  in  NSRC*RAW  decode / execute source addresses; re_d, re_e  in  NSRC  per-port read-enables.
REQ-008 wa_e, wa_m, wa_w  in  RAW  destination in E/M/W; regwrite_e, regwrite_m, regwrite_w  in  1.
REQ-009 memtoreg_e  in  1  load in E; mul_d, mul_e  in  1  multiply in D / E.
REQ-010 pcsrc_d, pcsrc_e, pcsrc_m, pcsrc_w  in  1  PC write pending per stage; branch_taken_e  in  1.
REQ-011 cnt_clr  in  1  synchronous clear of performance counters.
REQ-012 stall_f, stall_d, flush_d, flush_e  out  1  pipeline controls.
REQ-013 forward_e  out  NSRC*2  per-port select: 00 regfile, 01 ResultW, 10 ALUOutM.
REQ-014 mul_busy, mul_done  out  1; stall_cnt, flush_cnt  out  CNT_W.

Function
REQ-015 Forwarding per port i: 10 if re_e[i] & regwrite_m & ra_e[i]==wa_m; else 01 if re_e[i] & regwrite_w & ra_e[i]==wa_w; else 00; M beats W.
REQ-016 Address NREG-1 (PC) SHALL never be forwarded or trigger any dependency stall.
REQ-017 ldr_stall = memtoreg_e & regwrite_e & (any i: re_d[i] & ra_d[i]==wa_e).
REQ-018 Multiply issue: when mul_e & regwrite_e & ~mul_busy, down-counter loads MUL_LAT-1 and scoreboard bit sb[wa_e] sets at that edge.
REQ-019 mul_busy = (counter != 0); counter decrements each cycle while nonzero; mul_done = (counter == 1); sb cleared on the edge where counter goes 1->0.
REQ-020 mul_stall = any i: re_d[i] & (sb[ra_d[i]] | (mul_e & regwrite_e & ra_d[i]==wa_e)), OR mul_d & (mul_busy | mul_e); no bypass from multiplier; dependent released cycle after mul_done.
REQ-021 pcwr_pending = pcsrc_d | pcsrc_e | pcsrc_m.
REQ-022 stall_d = ldr_stall | mul_stall; stall_f = stall_d | pcwr_pending.
REQ-023 flush_e = stall_d | branch_taken_e; flush_d = pcwr_pending | pcsrc_w | branch_taken_e.
REQ-024 Flushes SHALL NOT cancel an issued multiply; counter and sb continue.
REQ-025 stall_cnt increments each cycle stall_d=1; flush_cnt each cycle (flush_d|flush_e)=1; both saturate at all-ones, never wrap.
REQ-026 cnt_clr has priority over increment: counter becomes 0 that edge.
REQ-027 All control/forward outputs combinational from inputs and current state; zero added latency.

Reset
REQ-028 reset_n low SHALL asynchronously zero counter, sb, stall_cnt, flush_cnt; mul_busy=mul_done=0 immediately.
REQ-029 Reset mid-multiply abandons it; no mul_done after release; with all inputs 0 every output is 0.

Structure
REQ-030 Package hazard_pkg holds fwd_sel_t (FWD_RF=00, FWD_W=01, FWD_M=10), default RAW/NSRC/MUL_LAT/CNT_W, and PC_REG = NREG-1.
REQ-031 Counter plus sb bits SHALL be sub-module mul_scoreboard; forwarding/stall logic stays in top.

Verification
REQ-032 ra_e[0]=3, re_e[0]=1, wa_m=wa_w=3, regwrite_m=regwrite_w=1 -> forward_e[1:0]=10; regwrite_m=0 -> 01; ra_e[0]=15 -> 00.
REQ-033 memtoreg_e=regwrite_e=1, wa_e=5, ra_d[1]=5, re_d[1]=1 -> stall_f=stall_d=flush_e=1 one cycle; re_d[1]=0 -> all 0.
REQ-034 MUL_LAT=3, mul_e=1, wa_e=7, then D reads r7 -> stall_d=1 for issue cycle plus 2; mul_busy 2 cycles; mul_done on 2nd; stall_d=0 next.
REQ-035 pcsrc_d=1 then propagate D->E->M->W -> stall_f 3 cycles, flush_d 4; branch_taken_e=1 -> flush_d=flush_e=1 same cycle.
REQ-036 Force stall_d for 2**CNT_W+3 cycles -> stall_cnt holds all-ones; cnt_clr=1 -> 0; reset_n low mid-multiply -> mul_busy=0 asynchronously, no mul_done.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and defaults for the hazard scoreboard.
//   fwd_sel_t  : forwarding mux select per execute source port
//   *_DEF      : default parameter values for the scoreboard and its sub-module
//   PC_REG     : register address of the PC (highest address) for the default RAW
package hazard_pkg;

   typedef enum logic [1:0] {
      FWD_RF = 2'b00,
      FWD_W  = 2'b01,
      FWD_M  = 2'b10
   } fwd_sel_t;

   localparam int unsigned RAW_DEF     = 4;
   localparam int unsigned NSRC_DEF    = 3;
   localparam int unsigned MUL_LAT_DEF = 3;
   localparam int unsigned CNT_W_DEF   = 16;
   localparam int unsigned NREG_DEF    = 2 ** RAW_DEF;
   localparam int unsigned PC_REG      = NREG_DEF - 1;

   // Wide enough for the largest legal multiply latency (15).
   localparam int unsigned MUL_CNT_W   = 4;

endpackage

// File: rtl/mul_scoreboard.sv
// Multiply latency tracker: a down-counter plus one pending-write bit per register.
//   clk, reset_n : clock, asynchronous active-low reset
//   issue        : multiply enters execute this cycle (already gated by ~busy)
//   issueAddr    : destination register of the issuing multiply
//   busy, done   : counter nonzero / counter equals one (result ready this cycle)
//   sb           : per-register pending bits, set at issue, cleared as the counter hits zero
module mul_scoreboard
   import hazard_pkg::*;
#(
   parameter int unsigned RAW     = RAW_DEF,
   parameter int unsigned MUL_LAT = MUL_LAT_DEF
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              issue,
   input  logic [RAW-1:0]    issueAddr,
   output logic              busy,
   output logic              done,
   output logic [2**RAW-1:0] sb
);

   logic [MUL_CNT_W-1:0] count;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
         sb    <= '0;
      end else if (issue) begin
         count          <= MUL_CNT_W'(MUL_LAT - 1);
         sb[issueAddr]  <= 1'b1;
      end else if (count != '0) begin
         count <= count - 1'b1;
         // Only one multiply is ever outstanding, so clearing the whole vector is exact.
         if (count == MUL_CNT_W'(1)) begin
            sb <= '0;
         end
      end
   end

   assign busy = (count != '0);
   assign done = (count == MUL_CNT_W'(1));

endmodule

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard unit: execute-stage forwarding, load-use and multiply stalls,
// PC-write stalls/flushes, and saturating stall/flush performance counters.
//   ra_d/re_d, ra_e/re_e            : decode / execute source addresses and read enables
//   wa_e/m/w, regwrite_e/m/w        : destinations and write enables in E/M/W
//   memtoreg_e, mul_d, mul_e        : load in E, multiply in D / E
//   pcsrc_d/e/m/w, branch_taken_e   : PC write pending per stage, taken branch in E
//   cnt_clr                         : synchronous clear of the performance counters
//   stall_f/d, flush_d/e, forward_e : pipeline controls (combinational)
//   mul_busy, mul_done              : multiplier status
//   stall_cnt, flush_cnt            : saturating performance counters
module hazard_scoreboard
   import hazard_pkg::*;
#(
   parameter int unsigned RAW     = RAW_DEF,
   parameter int unsigned NSRC    = NSRC_DEF,
   parameter int unsigned MUL_LAT = MUL_LAT_DEF,
   parameter int unsigned CNT_W   = CNT_W_DEF
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [NSRC*RAW-1:0] ra_d,
   input  logic [NSRC*RAW-1:0] ra_e,
   input  logic [NSRC-1:0]     re_d,
   input  logic [NSRC-1:0]     re_e,
   input  logic [RAW-1:0]      wa_e,
   input  logic [RAW-1:0]      wa_m,
   input  logic [RAW-1:0]      wa_w,
   input  logic                regwrite_e,
   input  logic                regwrite_m,
   input  logic                regwrite_w,
   input  logic                memtoreg_e,
   input  logic                mul_d,
   input  logic                mul_e,
   input  logic                pcsrc_d,
   input  logic                pcsrc_e,
   input  logic                pcsrc_m,
   input  logic                pcsrc_w,
   input  logic                branch_taken_e,
   input  logic                cnt_clr,
   output logic                stall_f,
   output logic                stall_d,
   output logic                flush_d,
   output logic                flush_e,
   output logic [NSRC*2-1:0]   forward_e,
   output logic                mul_busy,
   output logic                mul_done,
   output logic [CNT_W-1:0]    stall_cnt,
   output logic [CNT_W-1:0]    flush_cnt
);

   // The PC is the all-ones address; it is never forwarded and never stalls.
   localparam logic [RAW-1:0] PcAddr = {RAW{1'b1}};

   logic [2**RAW-1:0] sb;
   logic              mulIssue;
   logic              ldrStall;
   logic              mulStall;
   logic              pcwrPending;
   logic [RAW-1:0]    rdE;
   logic [RAW-1:0]    rdD;
   fwd_sel_t          fwdSel;

   // A flush of E never cancels a multiply that already issued; the sub-module keeps counting.
   assign mulIssue = mul_e & regwrite_e & ~mul_busy;

   mul_scoreboard #(
      .RAW     (RAW),
      .MUL_LAT (MUL_LAT)
   ) uMulSb (
      .clk       (clk),
      .reset_n   (reset_n),
      .issue     (mulIssue),
      .issueAddr (wa_e),
      .busy      (mul_busy),
      .done      (mul_done),
      .sb        (sb)
   );

   always_comb begin
      forward_e = '0;
      ldrStall  = 1'b0;
      mulStall  = 1'b0;
      rdE       = '0;
      rdD       = '0;
      fwdSel    = FWD_RF;
      for (int i = 0; i < int'(NSRC); i++) begin
         rdE    = ra_e[i*RAW +: RAW];
         rdD    = ra_d[i*RAW +: RAW];
         fwdSel = FWD_RF;
         if (re_e[i] && rdE != PcAddr) begin
            if (regwrite_m && rdE == wa_m) begin
               fwdSel = FWD_M;
            end else if (regwrite_w && rdE == wa_w) begin
               fwdSel = FWD_W;
            end
         end
         forward_e[i*2 +: 2] = fwdSel;
         if (re_d[i] && rdD != PcAddr) begin
            if (memtoreg_e && regwrite_e && rdD == wa_e) begin
               ldrStall = 1'b1;
            end
            // No bypass out of the multiplier: wait on both pending and issuing results.
            if (sb[rdD] || (mul_e && regwrite_e && rdD == wa_e)) begin
               mulStall = 1'b1;
            end
         end
      end
      // Single multiplier: a second multiply waits in D until the unit is free.
      mulStall    = mulStall | (mul_d & (mul_busy | mul_e));
      pcwrPending = pcsrc_d | pcsrc_e | pcsrc_m;
      stall_d     = ldrStall | mulStall;
      stall_f     = stall_d | pcwrPending;
      flush_e     = stall_d | branch_taken_e;
      flush_d     = pcwrPending | pcsrc_w | branch_taken_e;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else if (cnt_clr) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (stall_d && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + 1'b1;
         end
         if ((flush_d || flush_e) && flush_cnt != '1) begin
            flush_cnt <= flush_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed vector table, multi-cycle sequences,
// randomized stimulus against a cycle-count based reference model.
module tb_hazard_scoreboard;

   localparam int unsigned RAW     = 4;
   localparam int unsigned NSRC    = 3;
   localparam int unsigned MUL_LAT = 3;
   localparam int unsigned CNT_W   = 16;
   localparam int          PcInt   = (1 << RAW) - 1;
   localparam logic [RAW-1:0] PcAddr = RAW'(PcInt);
   localparam longint      CntMax  = (longint'(1) << CNT_W) - 1;

   logic                clk = 1'b0;
   logic                reset_n;
   logic [NSRC*RAW-1:0] ra_d, ra_e;
   logic [NSRC-1:0]     re_d, re_e;
   logic [RAW-1:0]      wa_e, wa_m, wa_w;
   logic                regwrite_e, regwrite_m, regwrite_w;
   logic                memtoreg_e, mul_d, mul_e;
   logic                pcsrc_d, pcsrc_e, pcsrc_m, pcsrc_w, branch_taken_e, cnt_clr;
   logic                stall_f, stall_d, flush_d, flush_e;
   logic [NSRC*2-1:0]   forward_e;
   logic                mul_busy, mul_done;
   logic [CNT_W-1:0]    stall_cnt, flush_cnt;

   int errors = 0;
   int checks = 0;

   // Reference model state: posedges since reset, multiply completion cycle, destination.
   int             cycNow;
   int             mEnd;
   logic [RAW-1:0] mDest;
   longint         sCnt, fCnt;

   hazard_scoreboard #(
      .RAW     (RAW),
      .NSRC    (NSRC),
      .MUL_LAT (MUL_LAT),
      .CNT_W   (CNT_W)
   ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .ra_d           (ra_d),
      .ra_e           (ra_e),
      .re_d           (re_d),
      .re_e           (re_e),
      .wa_e           (wa_e),
      .wa_m           (wa_m),
      .wa_w           (wa_w),
      .regwrite_e     (regwrite_e),
      .regwrite_m     (regwrite_m),
      .regwrite_w     (regwrite_w),
      .memtoreg_e     (memtoreg_e),
      .mul_d          (mul_d),
      .mul_e          (mul_e),
      .pcsrc_d        (pcsrc_d),
      .pcsrc_e        (pcsrc_e),
      .pcsrc_m        (pcsrc_m),
      .pcsrc_w        (pcsrc_w),
      .branch_taken_e (branch_taken_e),
      .cnt_clr        (cnt_clr),
      .stall_f        (stall_f),
      .stall_d        (stall_d),
      .flush_d        (flush_d),
      .flush_e        (flush_e),
      .forward_e      (forward_e),
      .mul_busy       (mul_busy),
      .mul_done       (mul_done),
      .stall_cnt      (stall_cnt),
      .flush_cnt      (flush_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [NSRC*RAW-1:0] raE;
      logic [NSRC-1:0]     reE;
      logic [RAW-1:0]      waM, waW;
      logic                rwM, rwW;
      logic [NSRC*RAW-1:0] raD;
      logic [NSRC-1:0]     reD;
      logic [RAW-1:0]      waE;
      logic                rwE, memE;
      logic [3:0]          pc;   // {w, m, e, d}
      logic                br;
      logic [NSRC*2-1:0]   fwd;
      logic                sf, sd, fd, fe;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   function automatic logic [NSRC*RAW-1:0] mkAddr(input int a0, input int a1, input int a2);
      logic [NSRC*RAW-1:0] r;
      r = '0;
      r[0*RAW +: RAW] = RAW'(a0);
      r[1*RAW +: RAW] = RAW'(a1);
      r[2*RAW +: RAW] = RAW'(a2);
      return r;
   endfunction

   task automatic idle();
      ra_d = '0; ra_e = '0; re_d = '0; re_e = '0;
      wa_e = '0; wa_m = '0; wa_w = '0;
      regwrite_e = 0; regwrite_m = 0; regwrite_w = 0;
      memtoreg_e = 0; mul_d = 0; mul_e = 0;
      pcsrc_d = 0; pcsrc_e = 0; pcsrc_m = 0; pcsrc_w = 0;
      branch_taken_e = 0; cnt_clr = 0;
   endtask

   task automatic doReset();
      @(negedge clk);
      idle();
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      cycNow = 0; mEnd = 0; mDest = '0; sCnt = 0; fCnt = 0;
   endtask

   task automatic ctl(input string tag, input logic sf, input logic sd, input logic fd,
                      input logic fe);
      chk({tag, ".stall_f"}, 64'(stall_f), 64'(sf));
      chk({tag, ".stall_d"}, 64'(stall_d), 64'(sd));
      chk({tag, ".flush_d"}, 64'(flush_d), 64'(fd));
      chk({tag, ".flush_e"}, 64'(flush_e), 64'(fe));
   endtask

   function automatic logic [RAW-1:0] rndReg();
      int v;
      v = int'($urandom_range(0, 4));
      return (v == 4) ? PcAddr : RAW'(v);
   endfunction

   // Expected outputs from the rules, then advance the model across the coming edge.
   task automatic modelStep();
      logic [RAW-1:0]    rE, rD;
      logic [NSRC*2-1:0] fwdExp;
      logic              ldr, mulS, busy, done, pcw, sd, sf, fd, fe;
      busy = (cycNow < mEnd);
      done = busy && (cycNow == mEnd - 1);
      fwdExp = '0; ldr = 0; mulS = 0;
      for (int i = 0; i < int'(NSRC); i++) begin
         rE = ra_e[i*RAW +: RAW];
         rD = ra_d[i*RAW +: RAW];
         if (re_e[i] && rE != PcAddr) begin
            if (regwrite_m && rE == wa_m)      fwdExp[i*2 +: 2] = 2'b10;
            else if (regwrite_w && rE == wa_w) fwdExp[i*2 +: 2] = 2'b01;
         end
         if (re_d[i] && rD != PcAddr) begin
            if (memtoreg_e && regwrite_e && rD == wa_e) ldr = 1;
            if ((busy && rD == mDest) || (mul_e && regwrite_e && rD == wa_e)) mulS = 1;
         end
      end
      if (mul_d && (busy || mul_e)) mulS = 1;
      pcw = pcsrc_d | pcsrc_e | pcsrc_m;
      sd  = ldr | mulS;
      sf  = sd | pcw;
      fe  = sd | branch_taken_e;
      fd  = pcw | pcsrc_w | branch_taken_e;
      chk("rnd.forward_e", 64'(forward_e), 64'(fwdExp));
      ctl("rnd", sf, sd, fd, fe);
      chk("rnd.mul_busy", 64'(mul_busy), 64'(busy));
      chk("rnd.mul_done", 64'(mul_done), 64'(done));
      chk("rnd.stall_cnt", 64'(stall_cnt), 64'(sCnt));
      chk("rnd.flush_cnt", 64'(flush_cnt), 64'(fCnt));
      if (mul_e && regwrite_e && !busy) begin
         mDest = wa_e;
         mEnd  = cycNow + int'(MUL_LAT);
      end
      cycNow++;
      if (cnt_clr) begin
         sCnt = 0; fCnt = 0;
      end else begin
         if (sd && sCnt < CntMax) sCnt++;
         if ((fd || fe) && fCnt < CntMax) fCnt++;
      end
   endtask

   initial begin
      idle();
      reset_n = 1'b0;
      #2;
      chk("reset.stall_f", 64'(stall_f), 0);
      chk("reset.flush_d", 64'(flush_d), 0);
      chk("reset.forward_e", 64'(forward_e), 0);
      chk("reset.mul_busy", 64'(mul_busy), 0);
      chk("reset.mul_done", 64'(mul_done), 0);
      chk("reset.stall_cnt", 64'(stall_cnt), 0);
      chk("reset.flush_cnt", 64'(flush_cnt), 0);
      doReset();

      // Directed vector table.
      vecs[0] = '{raE: mkAddr(3, 0, 0), reE: 3'b001, waM: 3, waW: 3, rwM: 1, rwW: 1,
                  raD: '0, reD: 0, waE: 0, rwE: 0, memE: 0, pc: 0, br: 0,
                  fwd: 6'b000010, sf: 0, sd: 0, fd: 0, fe: 0};
      vecs[1] = vecs[0]; vecs[1].rwM = 0; vecs[1].fwd = 6'b000001;
      vecs[2] = vecs[0]; vecs[2].raE = mkAddr(15, 0, 0); vecs[2].waM = 15; vecs[2].waW = 15;
      vecs[2].fwd = 6'b000000;
      vecs[3] = '{raE: mkAddr(3, 4, 3), reE: 3'b111, waM: 4, waW: 3, rwM: 1, rwW: 1,
                  raD: '0, reD: 0, waE: 0, rwE: 0, memE: 0, pc: 0, br: 0,
                  fwd: 6'b011001, sf: 0, sd: 0, fd: 0, fe: 0};
      vecs[4] = '{raE: '0, reE: 0, waM: 0, waW: 0, rwM: 0, rwW: 0,
                  raD: mkAddr(0, 5, 0), reD: 3'b010, waE: 5, rwE: 1, memE: 1, pc: 0, br: 0,
                  fwd: 0, sf: 1, sd: 1, fd: 0, fe: 1};
      vecs[5] = vecs[4]; vecs[5].reD = 0; vecs[5].sf = 0; vecs[5].sd = 0; vecs[5].fe = 0;
      vecs[6] = vecs[5]; vecs[6].raD = mkAddr(0, 15, 0); vecs[6].waE = 15; vecs[6].reD = 3'b010;
      vecs[7] = vecs[5]; vecs[7].memE = 0; vecs[7].br = 1; vecs[7].fd = 1; vecs[7].fe = 1;
      vecs[8] = vecs[5]; vecs[8].memE = 0; vecs[8].pc = 4'b0001; vecs[8].sf = 1; vecs[8].fd = 1;
      vecs[9] = vecs[5]; vecs[9].memE = 0; vecs[9].pc = 4'b1000; vecs[9].fd = 1;

      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         idle();
         ra_e = vecs[k].raE; re_e = vecs[k].reE; wa_m = vecs[k].waM; wa_w = vecs[k].waW;
         regwrite_m = vecs[k].rwM; regwrite_w = vecs[k].rwW;
         ra_d = vecs[k].raD; re_d = vecs[k].reD; wa_e = vecs[k].waE;
         regwrite_e = vecs[k].rwE; memtoreg_e = vecs[k].memE;
         {pcsrc_w, pcsrc_m, pcsrc_e, pcsrc_d} = vecs[k].pc;
         branch_taken_e = vecs[k].br;
         #1;
         chk($sformatf("vec%0d.forward_e", k), 64'(forward_e), 64'(vecs[k].fwd));
         ctl($sformatf("vec%0d", k), vecs[k].sf, vecs[k].sd, vecs[k].fd, vecs[k].fe);
      end

      // Multiply to r7 with a dependent reader in D.
      doReset();
      @(negedge clk);
      mul_e = 1; regwrite_e = 1; wa_e = 7; ra_d = mkAddr(7, 0, 0); re_d = 3'b001;
      #1;
      ctl("mul.issue", 1, 1, 0, 1);
      chk("mul.issue.busy", 64'(mul_busy), 0);
      @(negedge clk);
      mul_e = 0; regwrite_e = 0; wa_e = 0;
      #1;
      chk("mul.c1.stall_d", 64'(stall_d), 1);
      chk("mul.c1.busy", 64'(mul_busy), 1);
      chk("mul.c1.done", 64'(mul_done), 0);
      @(negedge clk);
      #1;
      chk("mul.c2.stall_d", 64'(stall_d), 1);
      chk("mul.c2.busy", 64'(mul_busy), 1);
      chk("mul.c2.done", 64'(mul_done), 1);
      @(negedge clk);
      #1;
      chk("mul.c3.stall_d", 64'(stall_d), 0);
      chk("mul.c3.busy", 64'(mul_busy), 0);
      chk("mul.c3.done", 64'(mul_done), 0);

      // PC write travelling D -> E -> M -> W, then a taken branch.
      for (int s = 0; s < 6; s++) begin
         @(negedge clk);
         idle();
         {pcsrc_w, pcsrc_m, pcsrc_e, pcsrc_d} = (s < 4) ? 4'(1 << s) : 4'b0000;
         branch_taken_e = (s == 5);
         #1;
         ctl($sformatf("pc%0d", s), s < 3, 0, s < 4 || s == 5, s == 5);
      end

      // Randomized run against the model.
      doReset();
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk);
         for (int i = 0; i < int'(NSRC); i++) begin
            ra_d[i*RAW +: RAW] = rndReg();
            ra_e[i*RAW +: RAW] = rndReg();
         end
         re_d = NSRC'($urandom); re_e = NSRC'($urandom);
         wa_e = rndReg(); wa_m = rndReg(); wa_w = rndReg();
         regwrite_e = 1'($urandom); regwrite_m = 1'($urandom); regwrite_w = 1'($urandom);
         memtoreg_e = ($urandom_range(0, 3) == 0);
         mul_e      = ($urandom_range(0, 3) == 0);
         mul_d      = ($urandom_range(0, 3) == 0);
         pcsrc_d    = ($urandom_range(0, 7) == 0);
         pcsrc_e    = ($urandom_range(0, 7) == 0);
         pcsrc_m    = ($urandom_range(0, 7) == 0);
         pcsrc_w    = ($urandom_range(0, 7) == 0);
         branch_taken_e = ($urandom_range(0, 7) == 0);
         cnt_clr    = ($urandom_range(0, 31) == 0);
         #1;
         modelStep();
      end

      // Counter saturation and clear priority under a held load-use stall.
      doReset();
      @(negedge clk);
      memtoreg_e = 1; regwrite_e = 1; wa_e = 5; ra_d = mkAddr(0, 5, 0); re_d = 3'b010;
      repeat ((1 << CNT_W) + 3) @(negedge clk);
      #1;
      chk("sat.stall_cnt", 64'(stall_cnt), 64'(CntMax));
      chk("sat.flush_cnt", 64'(flush_cnt), 64'(CntMax));
      cnt_clr = 1;
      @(negedge clk);
      cnt_clr = 0;
      #1;
      chk("clr.stall_cnt", 64'(stall_cnt), 0);
      chk("clr.flush_cnt", 64'(flush_cnt), 0);
      @(negedge clk);
      #1;
      chk("clr.resume.stall_cnt", 64'(stall_cnt), 1);

      // Reset in the middle of a multiply.
      doReset();
      @(negedge clk);
      mul_e = 1; regwrite_e = 1; wa_e = 2;
      @(negedge clk);
      idle();
      #1;
      chk("rstmul.busy", 64'(mul_busy), 1);
      #1;
      reset_n = 1'b0;
      #1;
      chk("rstmul.async.busy", 64'(mul_busy), 0);
      chk("rstmul.async.done", 64'(mul_done), 0);
      @(negedge clk);
      reset_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         #1;
         chk($sformatf("rstmul.after%0d.done", c), 64'(mul_done), 0);
         chk($sformatf("rstmul.after%0d.busy", c), 64'(mul_busy), 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
